branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl_if.sv | 34 +++
 rtl/branch_redirect_ctrl.sv | 101 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Branch-resolution / fetch-redirect bundle between the issue pipeline and the
// redirect controller. The pipeline side is the master, the controller the slave.
interface branch_redirect_ctrl_if;
  logic        s0_jump;
  logic        s0_jaccept;
  logic [31:0] s0_jaddr;
  logic        s1_jump;
  logic        s1_jaccept;
  logic [31:0] s1_jaddr;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        flush;
  logic        stall_issue;
  logic        s1_kill;
  logic [15:0] branch_cnt;
  logic [15:0] taken_cnt;

  modport master (
    output s0_jump, s0_jaccept, s0_jaddr,
    output s1_jump, s1_jaccept, s1_jaddr,
    output fetch_ready,
    input  redirect_valid, redirect_addr, flush, stall_issue, s1_kill,
    input  branch_cnt, taken_cnt
  );

  modport slave (
    input  s0_jump, s0_jaccept, s0_jaddr,
    input  s1_jump, s1_jaccept, s1_jaddr,
    input  fetch_ready,
    output redirect_valid, redirect_addr, flush, stall_issue, s1_kill,
    output branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Dual-slot branch redirect controller: picks the oldest taken branch, issues a
// redirect to fetch, then holds flush/stall for a fixed number of cycles.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic        s0_sel;
  logic        s1_sel;
  logic        kill_s1;
  logic [1:0]  br_inc;
  logic [16:0] br_sum;

  // Slot selection: the older slot always wins when both resolve taken.
  always_comb begin
    s0_sel  = bus.s0_jump & bus.s0_jaccept;
    s1_sel  = ~s0_sel & bus.s1_jump & bus.s1_jaccept;
    kill_s1 = (state_q == StIdle) & s0_sel;
  end

  // Next-state logic for the FSM, target latch, flush counter and statistics.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fcnt_d       = fcnt_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    // A killed slot 1 is on the wrong path and is not counted as resolved.
    br_inc       = {1'b0, bus.s0_jump} + {1'b0, bus.s1_jump & ~kill_s1};
    br_sum       = {1'b0, branch_cnt_q} + {15'd0, br_inc};

    unique case (state_q)
      StIdle: begin
        branch_cnt_d = br_sum[16] ? 16'hFFFF : br_sum[15:0];
        if (s0_sel || s1_sel) begin
          state_d = StRedirect;
          addr_d  = (s0_sel ? bus.s0_jaddr : bus.s1_jaddr) & ~32'd1;
          if (taken_cnt_q != 16'hFFFF) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
          end
        end
      end
      StRedirect: begin
        if (bus.fetch_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StFlush;
            fcnt_d  = 4'(FLUSH_CYCLES);
          end
        end
      end
      StFlush: begin
        fcnt_d = fcnt_q - 4'd1;
        // Leave on the cycle the counter would hit zero; <= also guards a stray 0.
        if (fcnt_q <= 4'd1) begin
          state_d = StIdle;
          fcnt_d  = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; branch inputs are ignored under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= 32'd0;
      fcnt_q       <= 4'd0;
      branch_cnt_q <= 16'd0;
      taken_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fcnt_q       <= fcnt_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_addr  = addr_q;
  assign bus.flush          = (state_q != StIdle);
  assign bus.stall_issue    = (state_q != StIdle);
  assign bus.s1_kill        = kill_s1;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a default build (2 flush cycles)
// checked through a redirect-address scoreboard plus direct checks, and a
// zero-flush build checked directly.
module tb_branch_redirect_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  branch_redirect_ctrl_if bus();
  branch_redirect_ctrl_if bus0();

  branch_redirect_ctrl #(.FLUSH_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_branches();
    bus.s0_jump     = 1'b0;
    bus.s0_jaccept  = 1'b0;
    bus.s0_jaddr    = 32'd0;
    bus.s1_jump     = 1'b0;
    bus.s1_jaccept  = 1'b0;
    bus.s1_jaddr    = 32'd0;
    bus0.s0_jump    = 1'b0;
    bus0.s0_jaccept = 1'b0;
    bus0.s0_jaddr   = 32'd0;
    bus0.s1_jump    = 1'b0;
    bus0.s1_jaccept = 1'b0;
    bus0.s1_jaddr   = 32'd0;
  endtask

  // Scoreboard: every completed handshake must match the oldest queued target.
  always @(negedge clk) begin
    if (!rst && bus.redirect_valid && bus.fetch_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_redirect", {31'd0, bus.redirect_valid}, 32'd0);
      end else begin
        check("sb_redirect_addr", bus.redirect_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_branches();
    bus.fetch_ready  = 1'b1;
    bus0.fetch_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_addr", bus.redirect_addr, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_issue}, 32'd0);
    check("rst_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
    check("rst_taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);

    // Slot 0 taken, odd target, immediate handshake, two flush cycles
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_1003;
    #1;
    check("a_s1_kill", {31'd0, bus.s1_kill}, 32'd1);
    exp_q.push_back(32'h0000_1002);
    tick();
    clear_branches();
    check("a_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("a_addr", bus.redirect_addr, 32'h0000_1002);
    check("a_flush_redir", {31'd0, bus.flush}, 32'd1);
    check("a_stall_redir", {31'd0, bus.stall_issue}, 32'd1);
    tick();
    check("a_fl1_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("a_fl1_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    check("a_fl2_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    check("a_idle_flush", {31'd0, bus.flush}, 32'd0);
    check("a_idle_stall", {31'd0, bus.stall_issue}, 32'd0);
    check("a_taken_cnt", {16'd0, bus.taken_cnt}, 32'd1);
    check("a_branch_cnt", {16'd0, bus.branch_cnt}, 32'd1);

    // Both slots taken: slot 0 wins, slot 1 not counted
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_0100;
    bus.s1_jump = 1'b1; bus.s1_jaccept = 1'b1; bus.s1_jaddr = 32'h0000_0200;
    #1;
    check("b_s1_kill", {31'd0, bus.s1_kill}, 32'd1);
    exp_q.push_back(32'h0000_0100);
    tick();
    clear_branches();
    check("b_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("b_addr", bus.redirect_addr, 32'h0000_0100);
    tick();
    tick();
    tick();
    check("b_branch_cnt", {16'd0, bus.branch_cnt}, 32'd2);
    check("b_taken_cnt", {16'd0, bus.taken_cnt}, 32'd2);

    // Slot 1 taken with slot 0 absent (jaccept without jump), fetch stalls 5 cycles
    bus.s0_jump = 1'b0; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_0999;
    bus.s1_jump = 1'b1; bus.s1_jaccept = 1'b1; bus.s1_jaddr = 32'h0000_0400;
    #1;
    check("c_s1_kill", {31'd0, bus.s1_kill}, 32'd0);
    exp_q.push_back(32'h0000_0400);
    tick();
    clear_branches();
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("c_hold_rv", {31'd0, bus.redirect_valid}, 32'd1);
      check("c_hold_addr", bus.redirect_addr, 32'h0000_0400);
      tick();
    end
    bus.fetch_ready = 1'b1;
    check("c_rv_6th", {31'd0, bus.redirect_valid}, 32'd1);
    tick();

    // Taken branches during FLUSH are wrong-path and ignored
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_0800;
    bus.s1_jump = 1'b1; bus.s1_jaccept = 1'b1; bus.s1_jaddr = 32'h0000_0900;
    #1;
    check("d_s1_kill", {31'd0, bus.s1_kill}, 32'd0);
    check("d_fl1_flush", {31'd0, bus.flush}, 32'd1);
    check("d_fl1_rv", {31'd0, bus.redirect_valid}, 32'd0);
    tick();
    check("d_fl2_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    clear_branches();
    check("d_idle_flush", {31'd0, bus.flush}, 32'd0);
    check("d_taken_cnt", {16'd0, bus.taken_cnt}, 32'd3);
    check("d_branch_cnt", {16'd0, bus.branch_cnt}, 32'd3);
    tick();
    check("d_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);

    // Reset while in REDIRECT, with a taken branch presented during reset
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_0055;
    bus.fetch_ready = 1'b0;
    tick();
    clear_branches();
    check("e_rv_pre", {31'd0, bus.redirect_valid}, 32'd1);
    rst = 1'b1;
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b1; bus.s0_jaddr = 32'h0000_0077;
    tick();
    rst = 1'b0;
    clear_branches();
    check("e_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("e_addr", bus.redirect_addr, 32'd0);
    check("e_flush", {31'd0, bus.flush}, 32'd0);
    check("e_stall", {31'd0, bus.stall_issue}, 32'd0);
    check("e_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
    check("e_taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);
    tick();
    check("e_rv_after", {31'd0, bus.redirect_valid}, 32'd0);
    bus.fetch_ready = 1'b1;

    // Zero-flush build: handshake returns straight to IDLE
    bus0.s0_jump = 1'b1; bus0.s0_jaccept = 1'b1; bus0.s0_jaddr = 32'h0000_2001;
    #1;
    check("f_s1_kill", {31'd0, bus0.s1_kill}, 32'd1);
    tick();
    clear_branches();
    check("f_rv", {31'd0, bus0.redirect_valid}, 32'd1);
    check("f_addr", bus0.redirect_addr, 32'h0000_2000);
    check("f_flush", {31'd0, bus0.flush}, 32'd1);
    tick();
    check("f_idle_rv", {31'd0, bus0.redirect_valid}, 32'd0);
    check("f_idle_flush", {31'd0, bus0.flush}, 32'd0);
    check("f_taken_cnt", {16'd0, bus0.taken_cnt}, 32'd1);

    // Not-taken slot 0 stream saturates branch_cnt without any redirect
    bus.s0_jump = 1'b1; bus.s0_jaccept = 1'b0; bus.s0_jaddr = 32'h0000_3000;
    repeat (65534) tick();
    check("g_branch_cnt_fffe", {16'd0, bus.branch_cnt}, 32'h0000_FFFE);
    tick();
    check("g_branch_cnt_ffff", {16'd0, bus.branch_cnt}, 32'h0000_FFFF);
    repeat (5) tick();
    clear_branches();
    check("g_branch_cnt_sat", {16'd0, bus.branch_cnt}, 32'h0000_FFFF);
    check("g_taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);
    check("g_rv", {31'd0, bus.redirect_valid}, 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
